swt_debounce: RTL and testbench

Input conditioning stage for the Basys3 slide switches. It sits directly upstream of the AOI logic and drives its `SWT[3:0]` input. Each raw switch bit passes through a two-flop synchronizer and a per-bit stability counter, so the downstream combinational logic and the 7-segment display never see metastable or bouncing values. An optional per-bit change pulse is also provided for later stages that need edge events.

---
 rtl/swt_pkg.sv | 9 +
 rtl/swt_debounce_bit.sv | 56 +++++
 rtl/swt_debounce.sv | 28 ++
 tb/tb_swt_debounce.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/swt_pkg.sv
// Shared board constants for the slide-switch input conditioning path.
package swt_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned SWT_N       = 4;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned SWT_CNT_MAX = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/swt_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and debounced level.
// SWT_DEBOUNCE_CHG_EN adds the registered one-cycle change pulse on chg.
module swt_debounce_bit import swt_pkg::*; #(
    parameter int unsigned CNT_MAX = SWT_CNT_MAX,
    parameter int unsigned CNT_W   = $clog2(CNT_MAX)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic swt,
    output logic chg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             update;

    // The new level has differed for CNT_MAX consecutive evaluations.
    assign update = (s2 != swt) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            swt <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == swt) begin
                cnt <= '0;
            end else if (update) begin
                swt <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SWT_DEBOUNCE_CHG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= 1'b0;
        end else begin
            chg <= update;
        end
    end
`else
    assign chg = 1'b0;
`endif

endmodule

// File: rtl/swt_debounce.sv
// Debounces N raw slide-switch pins; SWT feeds the AOI stage.
// SWT_CHG pulses only when built with SWT_DEBOUNCE_CHG_EN, otherwise tied to 0.
module swt_debounce import swt_pkg::*; #(
    parameter int unsigned N       = SWT_N,
    parameter int unsigned CNT_MAX = SWT_CNT_MAX,
    parameter int unsigned CNT_W   = $clog2(CNT_MAX)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] SWT_RAW,
    output logic [N-1:0] SWT,
    output logic [N-1:0] SWT_CHG
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        swt_debounce_bit #(
            .CNT_MAX (CNT_MAX),
            .CNT_W   (CNT_W)
        ) u_bit (
            .clk   (CLK),
            .rst_n (RST_N),
            .raw   (SWT_RAW[i]),
            .swt   (SWT[i]),
            .chg   (SWT_CHG[i])
        );
    end

endmodule

// File: tb/tb_swt_debounce.sv
// Directed bench for swt_debounce with CNT_MAX = 4 (6-cycle latency).
// Expected SWT_CHG is masked to 0 unless SWT_DEBOUNCE_CHG_EN is defined.
module tb_swt_debounce;

    localparam int unsigned N = 4;

`ifdef SWT_DEBOUNCE_CHG_EN
    localparam logic [N-1:0] CHG_MASK = 4'hF;
`else
    localparam logic [N-1:0] CHG_MASK = 4'h0;
`endif

    logic         CLK;
    logic         RST_N;
    logic [N-1:0] SWT_RAW;
    logic [N-1:0] SWT;
    logic [N-1:0] SWT_CHG;

    int errors;
    int checks;

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] swt;
        logic [N-1:0] chg;
    } vec_t;

    vec_t vecs[$];

    swt_debounce #(
        .N       (N),
        .CNT_MAX (4)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SWT_RAW (SWT_RAW),
        .SWT     (SWT),
        .SWT_CHG (SWT_CHG)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step(input logic [N-1:0] raw);
        SWT_RAW = raw;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] exp_swt,
                         input logic [N-1:0] exp_chg);
        logic [N-1:0] want_chg;
        want_chg = exp_chg & CHG_MASK;
        checks++;
        if (SWT !== exp_swt) begin
            errors++;
            $display("FAIL %s: SWT=%b want %b at %0t", name, SWT, exp_swt, $time);
        end
        checks++;
        if (SWT_CHG !== want_chg) begin
            errors++;
            $display("FAIL %s: SWT_CHG=%b want %b at %0t", name, SWT_CHG, want_chg, $time);
        end
    endtask

    task automatic add(input logic [N-1:0] raw, input logic [N-1:0] swt,
                       input logic [N-1:0] chg, input int n);
        vec_t v;
        v.raw = raw;
        v.swt = swt;
        v.chg = chg;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        RST_N   = 1'b1;
        SWT_RAW = '0;

        // Reset takes effect between clock edges.
        #3 RST_N = 1'b0;
        #1 check("async_reset", 4'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            step(4'hF);
            check("reset_hold", 4'h0, 4'h0);
        end
        RST_N = 1'b1;

        // Cycle-by-cycle vectors: reset release with switches high, fall,
        // clean edge on bit 0, and a simultaneous multi-bit update.
        add(4'hF, 4'h0, 4'h0, 5);
        add(4'hF, 4'hF, 4'hF, 1);
        add(4'hF, 4'hF, 4'h0, 1);
        add(4'h0, 4'hF, 4'h0, 5);
        add(4'h0, 4'h0, 4'hF, 1);
        add(4'h0, 4'h0, 4'h0, 1);
        add(4'h1, 4'h0, 4'h0, 5);
        add(4'h1, 4'h1, 4'h1, 1);
        add(4'h1, 4'h1, 4'h0, 1);
        add(4'h0, 4'h1, 4'h0, 5);
        add(4'h0, 4'h0, 4'h1, 1);
        add(4'h0, 4'h0, 4'h0, 1);
        add(4'hB, 4'h0, 4'h0, 5);
        add(4'hB, 4'hB, 4'hB, 1);
        add(4'hB, 4'hB, 4'h0, 1);
        add(4'h0, 4'hB, 4'h0, 5);
        add(4'h0, 4'h0, 4'hB, 1);
        add(4'h0, 4'h0, 4'h0, 1);
        foreach (vecs[i]) begin
            step(vecs[i].raw);
            check($sformatf("vec%0d", i), vecs[i].swt, vecs[i].chg);
        end

        // Glitch: 3 high, then 3-1-3 pattern; counter never completes.
        for (int k = 0; k < 3; k++) begin step(4'h2); check("glitch3", 4'h0, 4'h0); end
        for (int k = 0; k < 6; k++) begin step(4'h0); check("glitch3", 4'h0, 4'h0); end
        for (int k = 0; k < 3; k++) begin step(4'h2); check("glitch313", 4'h0, 4'h0); end
        step(4'h0); check("glitch313", 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin step(4'h2); check("glitch313", 4'h0, 4'h0); end
        for (int k = 0; k < 8; k++) begin step(4'h0); check("glitch313", 4'h0, 4'h0); end

        // Threshold: exactly 4 high cycles is accepted, then released.
        for (int k = 1; k <= 11; k++) begin
            step((k <= 4) ? 4'h4 : 4'h0);
            if (k <= 5)       check("threshold", 4'h0, 4'h0);
            else if (k == 6)  check("threshold_rise", 4'h4, 4'h4);
            else if (k <= 9)  check("threshold_hold", 4'h4, 4'h0);
            else if (k == 10) check("threshold_fall", 4'h0, 4'h4);
            else              check("threshold_idle", 4'h0, 4'h0);
        end

        // Reset mid-count discards the partial count.
        for (int k = 0; k < 3; k++) begin step(4'h8); check("midcount_pre", 4'h0, 4'h0); end
        RST_N = 1'b0;
        #1 check("midcount_reset", 4'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin step(4'h8); check("midcount_hold", 4'h0, 4'h0); end
        RST_N = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(4'h8);
            if (k <= 5)      check("midcount_wait", 4'h0, 4'h0);
            else if (k == 6) check("midcount_rise", 4'h8, 4'h8);
            else             check("midcount_hold_hi", 4'h8, 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
